decoder38_pulse: RTL and testbench

Sequenced 3-to-8 decoder with active-low outputs: the receiving end for codes produced by the team's 8-to-3 priority encoder. Each accepted 3-bit code drives exactly one output line low for a fixed number of cycles, followed by a one-cycle all-high gap. Codes arrive over a valid/ready handshake. An optional input FIFO lets an upstream encoder stream codes back-to-back.

---
 rtl/decoder38_pkg.sv | 19 +
 rtl/decoder38_fifo.sv | 51 +++++
 rtl/decoder38_pulse.sv | 118 +++++++++++
 tb/tb_decoder38_pulse.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder38_pkg.sv
// decoder38_pkg: shared types and helpers for the sequenced 3-to-8 decoder.
//   stateT       - FSM state encoding (IDLE, HOLD, GAP), 2 bits
//   ALL_OFF      - all decoded lines inactive (active-low, so all ones)
//   decode3to8() - active-low one-cold vector for a 3-bit code
package decoder38_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } stateT;

   localparam logic [7:0] ALL_OFF = 8'hFF;

   function automatic logic [7:0] decode3to8(input logic [2:0] code);
      return ~(8'b1 << code);
   endfunction

endpackage

// File: rtl/decoder38_fifo.sv
// decoder38_fifo: synchronous FIFO holding pending 3-bit codes.
// Ports:
//   iClk, iRst      - clock, asynchronous active-high reset (empties FIFO)
//   iPush, iData    - write a code; ignored when full
//   iPop            - drop the head entry; ignored when empty
//   oData           - head entry (valid while oEmpty is 0)
//   oFull, oEmpty   - occupancy flags
// DEPTH must be a power of two, 2 or more.
module decoder38_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iPush,
   input  logic [2:0] iData,
   input  logic       iPop,
   output logic [2:0] oData,
   output logic       oFull,
   output logic       oEmpty
);

   localparam int AW = $clog2(DEPTH);

   logic [2:0]  mem [DEPTH];
   logic [AW:0] wrPtr;
   logic [AW:0] rdPtr;
   logic        doPush;
   logic        doPop;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign oEmpty = (wrPtr == rdPtr);
   assign oFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPush = iPush && !oFull;
   assign doPop  = iPop && !oEmpty;
   assign oData  = mem[rdPtr[AW-1:0]];

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= iData;
   end

endmodule

// File: rtl/decoder38_pulse.sv
// decoder38_pulse: sequenced 3-to-8 decoder with active-low outputs.
// Each accepted code drives one line of oData low for HOLD_CYCLES cycles,
// followed by a single all-high gap cycle.
// Ports:
//   iClk, iRst      - clock, asynchronous active-high reset
//   iData, iValid   - code to decode and its valid strobe
//   oReady          - code accepted when iValid and oReady are both 1
//   iEI             - active-low enable; 1 freezes the sequence and blanks oData
//   oData           - registered active-low decoded lines
//   oEO             - active-low idle flag (enabled, idle, nothing queued)
// Build option: define DECODER38_PULSE_FIFO_EN to add a FIFO_DEPTH-entry input
// FIFO (decoder38_fifo) so codes can stream back-to-back; without it a single
// code register is loaded only in IDLE.
//
// state | meaning
// IDLE  | no pulse in progress, oData all high, waiting for a code
// HOLD  | selected line low, cnt counts remaining hold cycles down to 0
// GAP   | one all-high cycle separating consecutive pulses
module decoder38_pulse
   import decoder38_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [2:0] iData,
   input  logic       iValid,
   output logic       oReady,
   input  logic       iEI,
   output logic [7:0] oData,
   output logic       oEO
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   stateT            state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       code;
   logic             pending;
   logic [2:0]       nextCode;
   logic             slotFree;
   logic             loadNext;

   // A new code may only start from IDLE or straight out of GAP.
   assign slotFree = (state == IDLE) || (state == GAP);

`ifdef DECODER38_PULSE_FIFO_EN
   logic       fifoFull;
   logic       fifoEmpty;
   logic       fifoPush;
   logic [2:0] fifoData;

   assign oReady   = !iRst && !iEI && !fifoFull;
   assign fifoPush = iValid && oReady;
   assign pending  = !fifoEmpty;
   assign nextCode = fifoData;
   // Popping is tied to loading, so a disabled block never drains the FIFO.
   assign loadNext = !iEI && pending && slotFree;

   decoder38_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .iClk   (iClk),
      .iRst   (iRst),
      .iPush  (fifoPush),
      .iData  (iData),
      .iPop   (loadNext),
      .oData  (fifoData),
      .oFull  (fifoFull),
      .oEmpty (fifoEmpty)
   );
`else
   logic unusedFifoDepth;
   assign unusedFifoDepth = (FIFO_DEPTH != 0);

   assign oReady   = !iRst && !iEI && (state == IDLE);
   // The only pending code is the one being accepted this cycle.
   assign pending  = iValid && oReady;
   assign nextCode = iData;
   assign loadNext = pending && slotFree;
`endif

   assign oEO = iRst || iEI || (state != IDLE) || pending;

   // oData reflects the state of the previous cycle, so a pulse appears one
   // edge after the FSM enters HOLD and the gap one edge after GAP.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state <= IDLE;
         cnt   <= '0;
         code  <= '0;
         oData <= ALL_OFF;
      end else if (iEI) begin
         oData <= ALL_OFF;
      end else begin
         oData <= (state == HOLD) ? decode3to8(code) : ALL_OFF;
         case (state)
            IDLE, GAP: begin
               if (loadNext) begin
                  code  <= nextCode;
                  cnt   <= CNT_LOAD;
                  state <= HOLD;
               end else begin
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (cnt == '0) state <= GAP;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder38_pulse.sv
module tb_decoder38_pulse;

`ifdef DECODER38_PULSE_FIFO_EN
   localparam int HOLD  = 2;
   localparam int LAT   = 2;
`else
   localparam int HOLD  = 4;
   localparam int LAT   = 1;
`endif
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic [2:0] data;
   logic       valid;
   logic       ei;
   logic       oReady;
   logic [7:0] oData;
   logic       oEO;

   int nChecks = 0;
   int nFail   = 0;

   decoder38_pulse #(
      .HOLD_CYCLES (HOLD),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .iClk   (clk),
      .iRst   (rst),
      .iData  (data),
      .iValid (valid),
      .oReady (oReady),
      .iEI    (ei),
      .oData  (oData),
      .oEO    (oEO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] lineVec(input logic [2:0] c);
      logic [7:0] v;
      v = 8'hFF;
      v[c] = 1'b0;
      return v;
   endfunction

   // Behavioural model: every accepted code becomes a schedule of displayed
   // values (HOLD line vectors followed by one gap). Each enabled edge shows
   // the slot of the previous cycle and moves to the next one.
   logic [8:0] cur;          // {busy, value}; busy=0 means idle
   logic [8:0] sched [$];
   logic [2:0] pend  [$];
   logic [7:0] expData;
   logic       modelAcc;
   logic [2:0] modelCode;

   function automatic logic readyExp();
      if (rst || ei) return 1'b0;
`ifdef DECODER38_PULSE_FIFO_EN
      return pend.size() < DEPTH;
`else
      return !cur[8];
`endif
   endfunction

   function automatic logic eoExp();
      logic pendingNow;
`ifdef DECODER38_PULSE_FIFO_EN
      pendingNow = pend.size() > 0;
`else
      pendingNow = valid && readyExp();
`endif
      return ei || cur[8] || pendingNow;
   endfunction

   initial begin
      cur     = 9'h0FF;
      expData = 8'hFF;
   end

   always @(posedge clk) begin
      modelAcc = valid && readyExp();
      if (rst) begin
         cur = 9'h0FF;
         sched.delete();
         pend.delete();
         expData = 8'hFF;
      end else if (ei) begin
         expData = 8'hFF;
      end else begin
         expData = cur[7:0];
`ifndef DECODER38_PULSE_FIFO_EN
         if (modelAcc) pend.push_back(data);
`endif
         if (sched.size() > 0) begin
            cur = sched.pop_front();
         end else if (pend.size() > 0) begin
            modelCode = pend.pop_front();
            for (int k = 0; k < HOLD; k++) sched.push_back({1'b1, lineVec(modelCode)});
            sched.push_back({1'b1, 8'hFF});
            cur = sched.pop_front();
         end else begin
            cur = 9'h0FF;
         end
`ifdef DECODER38_PULSE_FIFO_EN
         if (modelAcc) pend.push_back(data);
`endif
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_data",  oData,          8'hFF);
         chk("rst_ready", {7'b0, oReady}, 8'h00);
         chk("rst_eo",    {7'b0, oEO},    8'h01);
      end else begin
         chk("model_data",  oData,          expData);
         chk("model_ready", {7'b0, oReady}, {7'b0, readyExp()});
         chk("model_eo",    {7'b0, oEO},    {7'b0, eoExp()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (oEO !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      chk("idle_wait", {7'b0, oEO}, 8'h00);
   endtask

   logic [7:0] tbl [8];
   logic [7:0] seqExp [9];
   logic [2:0] seqCodes [3];

   initial begin
      tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      seqExp = '{8'hFE, 8'hFE, 8'hFF, 8'h7F, 8'h7F, 8'hFF, 8'hFB, 8'hFB, 8'hFF};
      seqCodes = '{3'd0, 3'd7, 3'd2};

      rst = 1'b1; ei = 1'b0; valid = 1'b0; data = 3'd0;
      tick();
      tick();
      chk("reset_data",  oData,          8'hFF);
      chk("reset_ready", {7'b0, oReady}, 8'h00);
      chk("reset_eo",    {7'b0, oEO},    8'h01);
      rst = 1'b0;
      #1;
      chk("post_reset_eo",    {7'b0, oEO},    8'h00);
      chk("post_reset_ready", {7'b0, oReady}, 8'h01);

      // code 3: line low for HOLD cycles, one gap, ready again
      waitIdle();
      valid = 1'b1; data = 3'd3;
      tick();
      valid = 1'b0;
      repeat (LAT - 1) tick();
      for (int k = 0; k < HOLD; k++) begin
         tick();
         chk("code3_hold", oData, 8'hF7);
      end
      tick();
      chk("code3_gap", oData, 8'hFF);
      tick();
      chk("code3_ready", {7'b0, oReady}, 8'h01);

      // enable freeze in the middle of code 6
      waitIdle();
      valid = 1'b1; data = 3'd6;
      tick();
      valid = 1'b0;
      repeat (LAT - 1) tick();
      for (int k = 0; k < HOLD / 2; k++) begin
         tick();
         chk("freeze_pre", oData, 8'hBF);
      end
      ei = 1'b1;
      tick();
      chk("freeze_off", oData, 8'hFF);
      tick();
      chk("freeze_off2",   oData,          8'hFF);
      chk("freeze_eo",     {7'b0, oEO},    8'h01);
      chk("freeze_ready",  {7'b0, oReady}, 8'h00);
      ei = 1'b0;
      for (int k = 0; k < HOLD - HOLD / 2; k++) begin
         tick();
         chk("freeze_resume", oData, 8'hBF);
      end
      tick();
      chk("freeze_gap", oData, 8'hFF);

      // reset in the middle of code 5
      waitIdle();
      valid = 1'b1; data = 3'd5;
      tick();
      valid = 1'b0;
      repeat (LAT) tick();
      chk("midrst_hold", oData, 8'hDF);
      rst = 1'b1;
      #2;
      chk("midrst_data",  oData,          8'hFF);
      chk("midrst_ready", {7'b0, oReady}, 8'h00);
      chk("midrst_eo",    {7'b0, oEO},    8'h01);
      tick();
      chk("midrst_data2", oData, 8'hFF);
      rst = 1'b0;
      #1;
      chk("midrst_release_eo", {7'b0, oEO}, 8'h00);

      // exhaustive decode
      for (int c = 0; c < 8; c++) begin
         waitIdle();
         valid = 1'b1; data = 3'(c);
         tick();
         valid = 1'b0;
         repeat (LAT) tick();
         chk("decode_value", oData, tbl[c]);
         chk("decode_one_cold", 8'($countones(oData)), 8'd7);
      end

`ifdef DECODER38_PULSE_FIFO_EN
      // back-to-back streaming of 0, 7, 2
      waitIdle();
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; data = seqCodes[i];
         tick();
      end
      valid = 1'b0;
      chk("stream_0", oData, seqExp[0]);
      for (int j = 1; j < 9; j++) begin
         tick();
         chk("stream_seq", oData, seqExp[j]);
      end
      chk("stream_idle_eo", {7'b0, oEO}, 8'h00);

      // fill the FIFO while the decoder is busy
      waitIdle();
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1; data = 3'(i);
         tick();
         if (i == 5) chk("full_ready",    {7'b0, oReady}, 8'h00);
         if (i == 6) chk("full_ignored",  {7'b0, oReady}, 8'h00);
         if (i == 7) chk("full_released", {7'b0, oReady}, 8'h01);
      end
      valid = 1'b0;
      waitIdle();
`endif

      // randomized traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(99) == 0);
         ei    = ($urandom_range(9) == 0);
         valid = $urandom_range(1);
         data  = 3'($urandom_range(7));
         tick();
      end
      rst = 1'b0; ei = 1'b0; valid = 1'b0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
